// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational 32-bit ALU: decodes ALUOp/funct, drives registered
// operands and function code, captures the ALU result and returns it over valid/ready.
module alu_issue_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_aluop,
   input  logic [5:0]       in_funct,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_f,
   input  logic [WIDTH-1:0] alu_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic             out_err
);

   localparam logic [3:0] FAnd = 4'b0000;
   localparam logic [3:0] FOr  = 4'b0001;
   localparam logic [3:0] FAdd = 4'b0010;
   localparam logic [3:0] FSub = 4'b0110;
   localparam logic [3:0] FSlt = 4'b0111;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StResp
   } state_e;

   state_e           r_state;
   state_e           w_state_d;

   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [3:0]       r_alu_f;
   logic [WIDTH-1:0] r_out_y;
   logic             r_out_zero;
   logic             r_out_err;

   logic [3:0]       w_dec_f;
   logic             w_dec_err;
   logic             w_accept;
   logic             w_capture;

   // ALUOp 00/01 force ADD/SUB for loads, stores and branches; 1x defers to funct.
   always_comb begin
      w_dec_f   = FAdd;
      w_dec_err = 1'b0;
      if (in_aluop == 2'b00) begin
         w_dec_f = FAdd;
      end else if (in_aluop == 2'b01) begin
         w_dec_f = FSub;
      end else begin
         case (in_funct)
            6'b100000: w_dec_f = FAdd;
            6'b100010: w_dec_f = FSub;
            6'b100100: w_dec_f = FAnd;
            6'b100101: w_dec_f = FOr;
            6'b101010: w_dec_f = FSlt;
            default: begin
               w_dec_f   = r_alu_f;
               w_dec_err = 1'b1;
            end
         endcase
      end
   end

   assign w_accept  = in_valid && (r_state == StIdle);
   assign w_capture = (r_state == StExec);

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_state_d = w_dec_err ? StResp : StExec;
            end
         end
         StExec: w_state_d = StResp;
         StResp: begin
            if (out_ready) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_f    <= 4'b0000;
         r_out_y    <= '0;
         r_out_zero <= 1'b0;
         r_out_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_alu_a <= in_a;
            r_alu_b <= in_b;
            if (!w_dec_err) begin
               r_alu_f <= w_dec_f;
            end else begin
               // Error responses skip the ALU entirely.
               r_out_y    <= '0;
               r_out_zero <= 1'b1;
               r_out_err  <= 1'b1;
            end
         end
         if (w_capture) begin
            r_out_y    <= alu_y;
            r_out_zero <= (alu_y == '0);
            r_out_err  <= 1'b0;
         end
      end
   end

   assign in_ready  = (r_state == StIdle);
   assign out_valid = (r_state == StResp);
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_f     = r_alu_f;
   assign out_y     = r_out_y;
   assign out_zero  = r_out_zero;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, transaction-level reference model checked every
// cycle, directed literal cases and a randomized handshake phase.
module tb_alu_issue_ctrl;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   in_aluop = 2'b00;
   logic [5:0]   in_funct = 6'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_f;
   logic [W-1:0] alu_y;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_y;
   logic         out_zero;
   logic         out_err;

   int total = 0;
   int bad   = 0;

   alu_issue_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_aluop  (in_aluop),
      .in_funct  (in_funct),
      .in_a      (in_a),
      .in_b      (in_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_f     (alu_f),
      .alu_y     (alu_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_zero  (out_zero),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   // Combinational ALU the controller drives.
   always_comb begin
      alu_y = '0;
      case (alu_f)
         4'b0000: alu_y = alu_a & alu_b;
         4'b0001: alu_y = alu_a | alu_b;
         4'b0010: alu_y = alu_a + alu_b;
         4'b0110: alu_y = alu_a - alu_b;
         4'b0111: alu_y[0] = ($signed(alu_a) < $signed(alu_b));
         default: alu_y = '0;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: kind 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, -1 unsupported.
   function automatic int ref_kind(input logic [1:0] op, input logic [5:0] fn);
      if (op == 2'b00) return 0;
      if (op == 2'b01) return 1;
      case (fn)
         6'h20:   return 0;
         6'h22:   return 1;
         6'h24:   return 2;
         6'h25:   return 3;
         6'h2a:   return 4;
         default: return -1;
      endcase
   endfunction

   function automatic logic [3:0] ref_code(input int kind);
      case (kind)
         0:       return 4'd2;
         1:       return 4'd6;
         2:       return 4'd0;
         3:       return 4'd1;
         default: return 4'd7;
      endcase
   endfunction

   function automatic logic [W-1:0] ref_result(input int kind, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      case (kind)
         0:       return a + b;
         1:       return a - b;
         2:       return a & b;
         3:       return a | b;
         default: return (int'($signed(a)) < int'($signed(b))) ? 32'd1 : 32'd0;
      endcase
   endfunction

   // Model: one transaction in flight, a latency countdown, and the visible result fields.
   bit           m_started = 1'b0;
   bit           m_busy;
   int           m_wait;
   logic [W-1:0] m_res_y;
   logic [W-1:0] m_a, m_b, m_y;
   logic [3:0]   m_f;
   logic         m_z, m_e;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_started = 1'b1;
         m_busy = 1'b0; m_wait = 0; m_res_y = '0;
         m_a = '0; m_b = '0; m_f = 4'b0; m_y = '0; m_z = 1'b0; m_e = 1'b0;
      end else if (m_started) begin
         if (!m_busy) begin
            if (in_valid) begin
               int k;
               k = ref_kind(in_aluop, in_funct);
               m_a = in_a;
               m_b = in_b;
               m_busy = 1'b1;
               if (k >= 0) begin
                  m_f = ref_code(k);
                  m_res_y = ref_result(k, in_a, in_b);
                  m_wait = 1;
               end else begin
                  m_wait = 0;
                  m_y = '0; m_z = 1'b1; m_e = 1'b1;
               end
            end
         end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
               m_y = m_res_y; m_z = (m_res_y == '0); m_e = 1'b0;
            end
         end else if (out_ready) begin
            m_busy = 1'b0;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_started) begin
         chk("in_ready", 32'(in_ready), 32'(!m_busy));
         chk("out_valid", 32'(out_valid), 32'(m_busy && m_wait == 0));
         chk("out_y", out_y, m_y);
         chk("out_zero", 32'(out_zero), 32'(m_z));
         chk("out_err", 32'(out_err), 32'(m_e));
         chk("alu_a", alu_a, m_a);
         chk("alu_b", alu_b, m_b);
         chk("alu_f", 32'(alu_f), 32'(m_f));
      end
   end

   task automatic run_op(input string nm, input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ey,
                         input logic ez, input logic ee, input logic [3:0] ef, input int elat);
      int n;
      in_aluop = op; in_funct = fn; in_a = a; in_b = b;
      out_ready = 1'b1; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({nm, "_alu_f"}, 32'(alu_f), 32'(ef));
      n = 1;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      chk({nm, "_latency"}, n, elat);
      chk({nm, "_y"}, out_y, ey);
      chk({nm, "_zero"}, 32'(out_zero), 32'(ez));
      chk({nm, "_err"}, 32'(out_err), 32'(ee));
      @(posedge clk); #1;
      chk({nm, "_ready_back"}, 32'(in_ready), 32'd1);
      chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

   initial begin
      logic acc;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_alu_f", 32'(alu_f), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_y", out_y, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      run_op("add", 2'b00, 6'h00, 32'h5, 32'h3, 32'h8, 1'b0, 1'b0, 4'b0010, 2);
      run_op("sub0", 2'b10, 6'h22, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b0,
             4'b0110, 2);
      run_op("and", 2'b10, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0,
             4'b0000, 2);
      run_op("or", 2'b11, 6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0,
             4'b0001, 2);
      run_op("slt", 2'b10, 6'h2a, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h1, 1'b0, 1'b0,
             4'b0111, 2);
      run_op("err", 2'b10, 6'h07, 32'hAAAA_0000, 32'h5555, 32'h0, 1'b1, 1'b1, 4'b0111, 1);

      // Backpressure with a second request held behind the stalled response.
      in_aluop = 2'b00; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_aluop = 2'b01; in_a = 32'd9; in_b = 32'd4;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_y", out_y, 32'd2);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_xfer_valid", 32'(out_valid), 32'd0);
      chk("bp_xfer_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_held_alu_f", 32'(alu_f), 32'b0110);
      @(posedge clk); #1;
      chk("bp_held_valid", 32'(out_valid), 32'd1);
      chk("bp_held_y", out_y, 32'd5);
      @(posedge clk); #1;

      // Reset during EXEC aborts the operation.
      in_aluop = 2'b00; in_a = 32'd7; in_b = 32'd8; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("abort_valid", 32'(out_valid), 32'd0);
         chk("abort_ready", 32'(in_ready), 32'd1);
         chk("abort_alu_f", 32'(alu_f), 32'd0);
         chk("abort_out_y", out_y, 32'd0);
         chk("abort_alu_a", alu_a, 32'd0);
         @(posedge clk); #1;
      end

      // Randomized traffic; a request is held until accepted.
      acc = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if (acc || !in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_aluop = 2'($urandom_range(0, 3));
            in_funct = ($urandom_range(0, 4) != 0) ? fn_tab[$urandom_range(0, 4)]
                                                   : 6'($urandom);
            in_a = $urandom;
            in_b = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         acc = in_valid && in_ready;
         @(posedge clk); #1;
      end

      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
